aether_cmd_frontend: RTL and testbench

Parametrised command front-end for the Aether accelerator. It buffers host commands in a FIFO and applies backpressure when the FIFO is full. It decodes one command per cycle into register writes, register reads, reset pulses and task starts. It also owns the sticky/maskable interrupt block and the streaming memory read/write registers that feed the convolution and memory datapaths.

---
 rtl/aether_cmd_frontend_if.sv | 26 ++
 rtl/aether_cmd_frontend.sv | 152 +++++++++++++++
 tb/tb_aether_cmd_frontend.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/aether_cmd_frontend_if.sv
// aether_cmd_frontend_if: host command, register-read and memory-stream channels of the command front-end
// master = host side, slave = front-end side.
// cmd_i/cmd_valid_i/buffer_full_o        : command push channel with backpressure
// data_o/data_valid_o                    : register read results
// mem_wr_data_o/mem_wr_valid_o           : write-to-memory stream
// mem_rd_data_i/mem_rd_valid_i/mem_rd_ready_o : read-from-memory stream
interface aether_cmd_frontend_if #(parameter int DataWidth = 16);
  logic [DataWidth+7:0] cmd_i;
  logic                 cmd_valid_i;
  logic                 buffer_full_o;
  logic [DataWidth-1:0] data_o;
  logic                 data_valid_o;
  logic [DataWidth-1:0] mem_wr_data_o;
  logic                 mem_wr_valid_o;
  logic [DataWidth-1:0] mem_rd_data_i;
  logic                 mem_rd_valid_i;
  logic                 mem_rd_ready_o;
  modport master (
    output cmd_i, cmd_valid_i, mem_rd_data_i, mem_rd_valid_i,
    input  buffer_full_o, data_o, data_valid_o, mem_wr_data_o, mem_wr_valid_o, mem_rd_ready_o
  );
  modport slave (
    input  cmd_i, cmd_valid_i, mem_rd_data_i, mem_rd_valid_i,
    output buffer_full_o, data_o, data_valid_o, mem_wr_data_o, mem_wr_valid_o, mem_rd_ready_o
  );
endinterface

// File: rtl/aether_cmd_frontend.sv
// aether_cmd_frontend: command FIFO, one-per-cycle decoder, config/interrupt registers and memory stream glue
// clk_i/rst_i      : clock, synchronous active-high reset
// bus              : command, read-data and memory-stream channels (slave side)
// cfg_o            : config registers 1..6, reg1 in LSBs
// status_i         : live status, read at reg 7
// irq_event_i      : per-source interrupt events; interrupt_o = registered |(pending & mask)
// rst_conv_o/rst_weights_o/task_start_o/task_id_o/err_o : one-cycle command pulses
module aether_cmd_frontend #(
  parameter int                   DataWidth = 16,
  parameter int                   FifoDepth = 8,
  parameter int                   IrqCount  = 3,
  parameter logic [DataWidth-1:0] VersionId = 16'h0002
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  aether_cmd_frontend_if.slave   bus,
  output logic [6*DataWidth-1:0] cfg_o,
  input  logic [DataWidth-1:0]   status_i,
  input  logic [IrqCount-1:0]    irq_event_i,
  output logic                   interrupt_o,
  output logic                   rst_conv_o,
  output logic                   rst_weights_o,
  output logic                   task_start_o,
  output logic [3:0]             task_id_o,
  output logic                   err_o
);
  localparam int CmdWidth = DataWidth + 8;
  localparam int PtrW     = $clog2(FifoDepth);
  localparam int CntW     = PtrW + 1;
  logic [CmdWidth-1:0]  r_fifo [FifoDepth];
  logic [PtrW-1:0]      r_wptr, r_rptr;
  logic [CntW-1:0]      r_count, w_count_nxt;
  logic                 r_full;
  logic [DataWidth-1:0] r_cfg [1:6];
  logic [IrqCount-1:0]  r_mask, r_pending;
  logic [DataWidth-1:0] r_data, r_mem_wr_data;
  logic                 r_data_valid, r_err, r_rst_conv, r_rst_weights, r_task_start, r_mem_wr_valid, r_irq;
  logic [3:0]           r_task_id;
  logic [CmdWidth-1:0]  w_head;
  logic [3:0]           w_op, w_sub;
  logic [DataWidth-1:0] w_pay, w_rd_data;
  logic                 w_push, w_pop, w_is_rd15;
  logic                 w_rd, w_err, w_rc, w_rw, w_clr, w_cfg_we, w_mask_we, w_mem_we, w_task, w_pend_clr;
  assign w_head      = r_fifo[r_rptr];
  assign w_op        = w_head[CmdWidth-1 -: 4];
  assign w_sub       = w_head[CmdWidth-5 -: 4];
  assign w_pay       = w_head[DataWidth-1:0];
  assign w_is_rd15   = w_op == 4'd3 && w_sub == 4'd15;
  // A stream read at the head blocks the whole queue until the stream has data.
  assign w_pop       = !rst_i && r_count != '0 && !(w_is_rd15 && !bus.mem_rd_valid_i);
  assign w_push      = bus.cmd_valid_i && !r_full;
  assign w_count_nxt = r_count + CntW'(w_push) - CntW'(w_pop);
  always_comb begin
    w_rd       = 1'b0;
    w_rd_data  = '0;
    w_err      = 1'b0;
    w_rc       = 1'b0;
    w_rw       = 1'b0;
    w_clr      = 1'b0;
    w_cfg_we   = 1'b0;
    w_mask_we  = 1'b0;
    w_mem_we   = 1'b0;
    w_task     = 1'b0;
    w_pend_clr = 1'b0;
    if (w_pop)
      case (w_op)
        4'd0: begin
          w_rc  = w_sub == 4'd0 || w_sub == 4'd1;
          w_rw  = w_sub == 4'd0 || w_sub == 4'd2;
          w_clr = w_sub == 4'd0;
          w_err = w_sub > 4'd2;
        end
        4'd1: ;
        4'd2: begin
          w_cfg_we  = w_sub >= 4'd1 && w_sub <= 4'd6;
          w_mask_we = w_sub == 4'd8;
          w_mem_we  = w_sub == 4'd14;
          w_err     = w_sub == 4'd0 || w_sub == 4'd7 || w_sub == 4'd15;
        end
        4'd3: begin
          w_rd       = 1'b1;
          w_pend_clr = w_sub == 4'd8;
          w_err      = w_sub == 4'd14;
          w_rd_data  = w_sub == 4'd0  ? VersionId :
                       w_sub <= 4'd6  ? r_cfg[w_sub[2:0]] :
                       w_sub == 4'd7  ? status_i :
                       w_sub == 4'd8  ? DataWidth'(r_pending) :
                       w_sub == 4'd15 ? bus.mem_rd_data_i : '0;
        end
        4'd4: w_task = 1'b1;
        default: w_err = 1'b1;
      endcase
  end
  always_ff @(posedge clk_i)
    if (w_push) r_fifo[r_wptr] <= bus.cmd_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      for (int k = 1; k <= 6; k++) r_cfg[k] <= '0;
      r_mask         <= '0;
      r_pending      <= '0;
      r_data         <= '0;
      r_data_valid   <= 1'b0;
      r_err          <= 1'b0;
      r_rst_conv     <= 1'b0;
      r_rst_weights  <= 1'b0;
      r_task_start   <= 1'b0;
      r_task_id      <= '0;
      r_mem_wr_data  <= '0;
      r_mem_wr_valid <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
      r_count        <= w_count_nxt;
      r_full         <= w_count_nxt == CntW'(FifoDepth);
      if (w_clr) for (int k = 1; k <= 6; k++) r_cfg[k] <= '0;
      else if (w_cfg_we) r_cfg[w_sub[2:0]] <= w_pay;
      r_mask         <= w_clr ? '0 : w_mask_we ? w_pay[IrqCount-1:0] : r_mask;
      // Reset-all beats a coincident event; a new event beats clear-on-read.
      r_pending      <= w_clr ? '0 : (w_pend_clr ? '0 : r_pending) | irq_event_i;
      r_irq          <= |(r_pending & r_mask);
      if (w_rd) r_data <= w_rd_data;
      r_data_valid   <= w_rd;
      r_err          <= w_err;
      r_rst_conv     <= w_rc;
      r_rst_weights  <= w_rw;
      r_task_start   <= w_task;
      if (w_task) r_task_id <= w_sub;
      if (w_mem_we) r_mem_wr_data <= w_pay;
      r_mem_wr_valid <= w_mem_we;
    end
  end
  for (genvar i = 0; i < 6; i++) begin : g_cfg
    assign cfg_o[i*DataWidth +: DataWidth] = r_cfg[i+1];
  end
  assign bus.buffer_full_o  = r_full;
  assign bus.data_o         = r_data;
  assign bus.data_valid_o   = r_data_valid;
  assign bus.mem_wr_data_o  = r_mem_wr_data;
  assign bus.mem_wr_valid_o = r_mem_wr_valid;
  assign bus.mem_rd_ready_o = w_pop && w_is_rd15;
  assign interrupt_o        = r_irq;
  assign rst_conv_o         = r_rst_conv;
  assign rst_weights_o      = r_rst_weights;
  assign task_start_o       = r_task_start;
  assign task_id_o          = r_task_id;
  assign err_o              = r_err;
endmodule

// File: tb/tb_aether_cmd_frontend.sv
// tb_aether_cmd_frontend: directed scoreboard bench for the command front-end
module tb_aether_cmd_frontend;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] cfg;
  logic [15:0] status;
  logic [2:0]  irq;
  logic        intr, rc, rw, ts, err;
  logic [3:0]  tid;
  always #5 clk = ~clk;
  aether_cmd_frontend_if #(.DataWidth(16)) bus();
  aether_cmd_frontend dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave), .cfg_o(cfg), .status_i(status),
    .irq_event_i(irq), .interrupt_o(intr), .rst_conv_o(rc), .rst_weights_o(rw),
    .task_start_o(ts), .task_id_o(tid), .err_o(err)
  );
  typedef struct packed {
    logic        dv;
    logic [15:0] d;
    logic        er, rc, rw, ts;
    logic [3:0]  tid;
    logic        mw;
    logic [15:0] md;
  } ev_t;
  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  function automatic ev_t mk(input logic dv, input logic [15:0] d, input logic er, input logic c,
                             input logic w, input logic t, input logic [3:0] id, input logic mw,
                             input logic [15:0] md);
    mk = '{dv, d, er, c, w, t, id, mw, md};
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic issue(input logic [23:0] c);
    bus.cmd_i = c;
    bus.cmd_valid_i = 1'b1;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask
  task automatic issue_x(input logic [23:0] c, input ev_t e);
    exp_q.push_back(e);
    issue(c);
  endtask
  always @(negedge clk) begin
    if (!rst && (bus.data_valid_o || err || rc || rw || ts || bus.mem_wr_valid_o)) begin
      ev_t a;
      a = mk(bus.data_valid_o, bus.data_valid_o ? bus.data_o : 16'h0, err, rc, rw, ts,
             ts ? tid : 4'h0, bus.mem_wr_valid_o, bus.mem_wr_valid_o ? bus.mem_wr_data_o : 16'h0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected nothing", a);
      end else chk("output_event", a, exp_q.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd_i = '0;
    bus.cmd_valid_i = 1'b0;
    bus.mem_rd_data_i = '0;
    bus.mem_rd_valid_i = 1'b0;
    status = 16'h5A5A;
    irq = '0;
    tick(3);
    rst = 1'b0;
    chk("rst_full", bus.buffer_full_o, 0);
    chk("rst_dv", bus.data_valid_o, 0);
    chk("rst_err", err, 0);
    chk("rst_intr", intr, 0);
    chk("rst_cfg", cfg, 0);
    chk("rst_pulses", {rc, rw, ts, bus.mem_wr_valid_o, bus.mem_rd_ready_o}, 0);
    // latency: accepted at edge T, visible after edge T+1
    issue_x(24'h300000, mk(1, 16'h0002, 0, 0, 0, 0, 0, 0, 0));
    chk("lat_early", bus.data_valid_o, 0);
    @(negedge clk);
    chk("lat_on_time", bus.data_valid_o, 1);
    tick(2);
    // write then read back-to-back
    issue(24'h23BEEF);
    issue_x(24'h330000, mk(1, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0));
    issue(24'h266666);
    issue_x(24'h360000, mk(1, 16'h6666, 0, 0, 0, 0, 0, 0, 0));
    issue_x(24'h370000, mk(1, 16'h5A5A, 0, 0, 0, 0, 0, 0, 0));
    issue_x(24'h3A0000, mk(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
    tick(3);
    chk("cfg_written", cfg, 96'h6666_0000_0000_BEEF_0000_0000);
    // stall on stream read, fill FIFO
    issue_x(24'h3F0000, mk(1, 16'h1234, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 7; k++)
      issue_x({8'h2E, 16'(16'h0A00 + k)}, mk(0, 0, 0, 0, 0, 0, 0, 1, 16'(16'h0A00 + k)));
    chk("full_after_8", bus.buffer_full_o, 1);
    chk("ready_stalled", bus.mem_rd_ready_o, 0);
    issue(24'h2EDEAD);
    chk("full_after_9th", bus.buffer_full_o, 1);
    bus.mem_rd_data_i = 16'h1234;
    bus.mem_rd_valid_i = 1'b1;
    #1;
    chk("ready_comb", bus.mem_rd_ready_o, 1);
    @(negedge clk);
    chk("ready_single", bus.mem_rd_ready_o, 0);
    chk("full_dropped", bus.buffer_full_o, 0);
    bus.mem_rd_valid_i = 1'b0;
    tick(10);
    // interrupts
    issue(24'h280002);
    tick(2);
    irq = 3'b001;
    @(negedge clk);
    irq = 3'b000;
    tick(2);
    chk("irq_masked", intr, 0);
    irq = 3'b010;
    @(negedge clk);
    irq = 3'b000;
    chk("irq_registered", intr, 0);
    @(negedge clk);
    chk("irq_raised", intr, 1);
    issue_x(24'h380000, mk(1, 16'h0003, 0, 0, 0, 0, 0, 0, 0));
    tick(3);
    chk("irq_cleared", intr, 0);
    irq = 3'b010;
    @(negedge clk);
    irq = 3'b000;
    tick(2);
    chk("irq_again", intr, 1);
    issue_x(24'h380000, mk(1, 16'h0002, 0, 0, 0, 0, 0, 0, 0));
    irq = 3'b010;
    @(negedge clk);
    irq = 3'b000;
    tick(3);
    chk("irq_set_wins", intr, 1);
    issue_x(24'h380000, mk(1, 16'h0002, 0, 0, 0, 0, 0, 0, 0));
    tick(3);
    chk("irq_final_clear", intr, 0);
    // illegal and ignored commands
    issue_x(24'h700000, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    issue_x(24'h200055, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    issue_x(24'h050000, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    issue_x(24'h3E0000, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    issue_x(24'h2F1234, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    issue_x(24'h271234, mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    issue(24'h291234);
    issue(24'h100000);
    tick(3);
    chk("cfg_after_illegal", cfg, 96'h6666_0000_0000_BEEF_0000_0000);
    // reset-all, partial resets, task start
    issue(24'h280002);
    irq = 3'b010;
    @(negedge clk);
    irq = 3'b000;
    tick(3);
    chk("irq_before_rstall", intr, 1);
    issue(24'h211111);
    issue_x(24'h000000, mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    tick(3);
    chk("cfg_rstall", cfg, 0);
    chk("irq_rstall", intr, 0);
    irq = 3'b010;
    @(negedge clk);
    irq = 3'b000;
    tick(3);
    chk("mask_rstall", intr, 0);
    issue_x(24'h380000, mk(1, 16'h0002, 0, 0, 0, 0, 0, 0, 0));
    issue_x(24'h010000, mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    issue_x(24'h020000, mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    issue_x(24'h4A0000, mk(0, 0, 0, 0, 0, 1, 4'hA, 0, 0));
    issue_x(24'h310000, mk(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
    tick(3);
    // reset with commands queued behind a stalled head
    issue(24'h3F0000);
    issue(24'h4A0000);
    issue(24'h000000);
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rst_q_full", bus.buffer_full_o, 0);
    bus.mem_rd_valid_i = 1'b1;
    #1;
    chk("rst_q_empty", bus.mem_rd_ready_o, 0);
    tick(5);
    bus.mem_rd_valid_i = 1'b0;
    issue_x(24'h300000, mk(1, 16'h0002, 0, 0, 0, 0, 0, 0, 0));
    tick(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
